sys_sum_stacker: RTL and testbench
==================================

Name: sys_sum_stacker

Overview:
- Combined systolic adder and output packer for the multiprecision CNN datapath.
- Accepts NumOfNerves diagonally skewed lanes from a neuron array and sums across lanes per element. Each frame carries DepthIn elements.
- Packs the resulting serial sum stream into words of NumOfNerves/DepthOut lanes for the next layer.

Parameters:
- BitSize, 4: width of every data element and of each sum (unsigned).
- NumOfNerves, 4: number of input lanes. Must be a multiple of DepthOut.
- DepthIn, 2: elements per frame, i.e. sums produced per frame.
- DepthOut, 2: packing divisor. Output word holds W = NumOfNerves/DepthOut lanes.

Ports:
- clk, input, 1: single clock, rising edge.
- res_n, input, 1: synchronous, active-high reset. The name is kept from the codebase; it is asserted when high.
- in_valid, input, 1: in_data lanes are valid this cycle.
- in_start, input, 1: head-lane element strobe. Lane NumOfNerves-1 carries a new element.
- in_data, input, NumOfNerves*BitSize: lane k occupies bits [k*BitSize +: BitSize].
- out_valid_sum, output, 1: serial sum valid.
- out_start_sum, output, 1: first sum of a frame.
- out_data_sum, output, BitSize: serial sum.
- out_valid, output, 1: packed word valid, one-cycle pulse.
- out_start, output, 1: first packed word of a frame.
- out_data, output, W*BitSize: packed word. Lane 0 holds the earliest sum.

Behaviour:
- Reset: all registers and all outputs go to 0, including pipeline, counters and partial word. A reset mid-frame discards the frame.
- Input skew: lane k element j is presented (NumOfNerves-1-k) cycles after the head lane NumOfNerves-1 element j.
- Head element: one is sampled when in_start && in_valid.
- Lane gating: a lane value is used only when in_valid is 1; otherwise that lane contributes 0.
- Systolic chain:
  - p[N-1] <= lane[N-1].
  - p[k] <= p[k+1] + lane[k], for k from N-2 down to 0.
- Pipeline valid: a head-strobe valid bit travels alongside the chain.
- Sum output:
  - out_data_sum = p[0].
  - out_valid_sum is asserted after edge t+N-1, where t is the edge that sampled head element j and N = NumOfNerves.
- Arithmetic: unsigned, wraps modulo 2^BitSize (default).
- Frame element counter: 0..DepthIn-1, advanced on each out_valid_sum.
  - out_start_sum = out_valid_sum && count==0.
  - The counter wraps after DepthIn-1, so a burst longer than DepthIn starts a new frame.
- Stacker:
  - On each valid sum, writes the sum into lane position pos (0..W-1).
  - out_start is latched from the first sum of the word.
- Word complete: when pos==W-1, or when the sum is the last element of the frame (count==DepthIn-1).
  - At that same edge: out_data is updated, out_valid=1 for one cycle, and the partial word clears.
  - Unfilled lanes are 0.
- out_start is 1 only on the first word of a frame.
- Latency: first word of a frame (W <= DepthIn) is visible after edge t0+N+W-1, where t0 is the edge sampling the frame's first head element.
- Continuous back-to-back frames are supported. No backpressure.
- out_data holds its value between pulses.

Optional Feature:
- Macro SYS_SUM_SATURATE_EN.
  - Defined: each chain addition saturates at 2^BitSize-1 (unsigned clamp).
  - Undefined: additions wrap modulo 2^BitSize.

Decomposition:
- Package sys_sum_stacker_pkg:
  - localparam function computing W.
  - Element typedef logic [BitSize-1:0].
  - Elaboration check that NumOfNerves % DepthOut == 0.
- One sub-module: sys_sum_cell, a single registered adder stage (lane input, upstream partial, registered partial out, valid pipe), with the saturation option. Instantiate it NumOfNerves times.

Test Plan:
- Basic frame, defaults, values a=1 b=2 c=3:
  - Lane3 = 1,1; lane2 = 3,3; lane1 = 2,2; lane0 = 1,2, skewed.
  - in_start high 2 cycles; in_valid high 5 cycles.
  - Expect sums 7 then 8; out_start_sum on 7.
  - Expect one out_valid with out_start=1 and out_data=8'h87.
- Repeated frame after an 8-cycle gap: identical stimulus produces a second out_valid with out_data=8'h87 and out_start=1.
- Overflow: all lanes 4'hF for one element.
  - Wrap (default): sum 4'hC.
  - SYS_SUM_SATURATE_EN: sum 4'hF.
- Partial word: DepthIn=3, all lanes 1 → sums 4,4,4.
  - Word 1 = 8'h44 with out_start=1.
  - Word 2 = 8'h04 with out_start=0.
- Reset mid-frame: assert res_n after the first sum.
  - All outputs become 0; no out_valid for the aborted frame.
  - The next full frame again yields 8'h87.
- in_valid low with in_start high: no sum produced, counters unchanged, outputs 0.

Source files
------------

// File: rtl/sys_sum_stacker_pkg.sv
// Shared types and elaboration helpers for the systolic sum/stacker datapath.
package sys_sum_stacker_pkg;

  localparam int unsigned BIT_SIZE_DFLT = 4;

  typedef logic [BIT_SIZE_DFLT-1:0] elem_t;

  // Lanes per packed output word.
  function automatic int unsigned calc_w(input int unsigned nerves, input int unsigned depth_out);
    return nerves / depth_out;
  endfunction

  // Index width that stays legal when the range collapses to a single value.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit cfg_ok(input int unsigned nerves, input int unsigned depth_out,
                                input int unsigned depth_in);
    return (depth_out != 0) && (nerves % depth_out == 0) && (nerves >= 2) && (depth_in != 0);
  endfunction

endpackage

// File: rtl/sys_sum_cell.sv
// One registered stage of the systolic adder chain with its valid pipe bit.
// Optional build macro SYS_SUM_SATURATE_EN clamps the addition instead of wrapping.
module sys_sum_cell
  import sys_sum_stacker_pkg::*;
#(
  parameter int unsigned BitSize = BIT_SIZE_DFLT
) (
  input  logic               clk,
  input  logic               res_n,
  input  logic [BitSize-1:0] in_lane,
  input  logic [BitSize-1:0] in_part,
  input  logic               in_vld,
  output logic [BitSize-1:0] out_part,
  output logic               out_vld
);

  logic [BitSize-1:0] part_q, part_d;
  logic               vld_q, vld_d;

`ifdef SYS_SUM_SATURATE_EN
  logic [BitSize:0] sum_w;
  assign sum_w = {1'b0, in_part} + {1'b0, in_lane};
`endif

  always_comb begin
    vld_d = in_vld;
`ifdef SYS_SUM_SATURATE_EN
    part_d = sum_w[BitSize] ? '1 : sum_w[BitSize-1:0];
`else
    part_d = in_part + in_lane;
`endif
  end

  always_ff @(posedge clk) begin
    if (res_n) begin
      part_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      part_q <= part_d;
      vld_q  <= vld_d;
    end
  end

  assign out_part = part_q;
  assign out_vld  = vld_q;

endmodule

// File: rtl/sys_sum_stacker.sv
// Systolic cross-lane adder feeding a frame-aware packer of serial sums into words.
// Build macro SYS_SUM_SATURATE_EN selects saturating chain additions (see sys_sum_cell).
module sys_sum_stacker
  import sys_sum_stacker_pkg::*;
#(
  parameter int unsigned BitSize     = BIT_SIZE_DFLT,
  parameter int unsigned NumOfNerves = 4,
  parameter int unsigned DepthIn     = 2,
  parameter int unsigned DepthOut    = 2
) (
  input  logic                                   clk,
  input  logic                                   res_n,
  input  logic                                   in_valid,
  input  logic                                   in_start,
  input  logic [NumOfNerves*BitSize-1:0]         in_data,
  output logic                                   out_valid_sum,
  output logic                                   out_start_sum,
  output logic [BitSize-1:0]                     out_data_sum,
  output logic                                   out_valid,
  output logic                                   out_start,
  output logic [(NumOfNerves/DepthOut)*BitSize-1:0] out_data
);

  localparam int unsigned W     = calc_w(NumOfNerves, DepthOut);
  localparam int unsigned WordW = W * BitSize;
  localparam int unsigned CntW  = idx_w(DepthIn);
  localparam int unsigned PosW  = idx_w(W);

  if (!cfg_ok(NumOfNerves, DepthOut, DepthIn)) begin : g_cfg_err
    $error("sys_sum_stacker: NumOfNerves must be >=2 and a multiple of DepthOut");
  end

  logic [BitSize-1:0] part_w [NumOfNerves];
  logic               vld_w  [NumOfNerves];

  // Head lane starts the chain; each lower lane adds onto its upstream partial.
  for (genvar k = 0; k < NumOfNerves; k++) begin : g_chain
    logic [BitSize-1:0] lane;
    logic [BitSize-1:0] up_part;
    logic               up_vld;

    assign lane = in_valid ? in_data[k*BitSize +: BitSize] : '0;

    if (k == NumOfNerves - 1) begin : g_head
      assign up_part = '0;
      assign up_vld  = in_start & in_valid;
    end else begin : g_body
      assign up_part = part_w[k+1];
      assign up_vld  = vld_w[k+1];
    end

    sys_sum_cell #(.BitSize(BitSize)) u_cell (
      .clk      (clk),
      .res_n    (res_n),
      .in_lane  (lane),
      .in_part  (up_part),
      .in_vld   (up_vld),
      .out_part (part_w[k]),
      .out_vld  (vld_w[k])
    );
  end

  logic [CntW-1:0]  count_q, count_d;
  logic [PosW-1:0]  pos_q, pos_d;
  logic [WordW-1:0] word_q, word_d;
  logic             wstart_q, wstart_d;
  logic             out_start_sum_q, out_start_sum_d;
  logic             out_valid_q, out_valid_d;
  logic             out_start_q, out_start_d;
  logic [WordW-1:0] out_data_q, out_data_d;
  logic [WordW-1:0] word_ins;
  logic             frame_end;
  logic             word_full;

  // Frame counting and packing act on the edge that consumes the presented sum.
  always_comb begin
    count_d         = count_q;
    pos_d           = pos_q;
    word_d          = word_q;
    wstart_d        = wstart_q;
    out_valid_d     = 1'b0;
    out_start_d     = 1'b0;
    out_data_d      = out_data_q;
    out_start_sum_d = 1'b0;
    frame_end       = (count_q == CntW'(DepthIn - 1));
    word_full       = (pos_q == PosW'(W - 1));

    word_ins = word_q;
    for (int unsigned l = 0; l < W; l++) begin
      if (pos_q == PosW'(l)) begin
        word_ins[l*BitSize +: BitSize] = part_w[0];
      end
    end

    if (vld_w[0]) begin
      count_d = frame_end ? '0 : count_q + CntW'(1);
      if (pos_q == '0) begin
        wstart_d = out_start_sum_q;
      end
      if (word_full || frame_end) begin
        out_valid_d = 1'b1;
        out_start_d = (pos_q == '0) ? out_start_sum_q : wstart_q;
        out_data_d  = word_ins;
        word_d      = '0;
        pos_d       = '0;
      end else begin
        word_d = word_ins;
        pos_d  = pos_q + PosW'(1);
      end
    end

    // Registered frame-start flag lines up with the sum entering the last stage.
    out_start_sum_d = vld_w[1] & (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (res_n) begin
      count_q         <= '0;
      pos_q           <= '0;
      word_q          <= '0;
      wstart_q        <= 1'b0;
      out_start_sum_q <= 1'b0;
      out_valid_q     <= 1'b0;
      out_start_q     <= 1'b0;
      out_data_q      <= '0;
    end else begin
      count_q         <= count_d;
      pos_q           <= pos_d;
      word_q          <= word_d;
      wstart_q        <= wstart_d;
      out_start_sum_q <= out_start_sum_d;
      out_valid_q     <= out_valid_d;
      out_start_q     <= out_start_d;
      out_data_q      <= out_data_d;
    end
  end

  assign out_valid_sum = vld_w[0];
  assign out_data_sum  = part_w[0];
  assign out_start_sum = out_start_sum_q;
  assign out_valid     = out_valid_q;
  assign out_start     = out_start_q;
  assign out_data      = out_data_q;

endmodule

// File: tb/tb_sys_sum_stacker.sv
// Bench for sys_sum_stacker: two instances (DepthIn 2 and 3) against a cycle-indexed sum/packing model.
module tb_sys_sum_stacker;
  import sys_sum_stacker_pkg::*;

  localparam int unsigned N    = 4;
  localparam int unsigned B    = 4;
  localparam int unsigned W    = 2;
  localparam int          MaxE = 4096;

  logic        clk = 1'b0;
  logic        res_n;
  logic        in_valid;
  logic        in_start;
  logic [15:0] in_data;
  logic        ovs [2];
  logic        oss [2];
  logic [3:0]  ods [2];
  logic        ov  [2];
  logic        os  [2];
  logic [7:0]  od  [2];

  always #5 clk = ~clk;

  sys_sum_stacker #(.BitSize(4), .NumOfNerves(4), .DepthIn(2), .DepthOut(2)) u_dut0 (
    .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_start(in_start), .in_data(in_data),
    .out_valid_sum(ovs[0]), .out_start_sum(oss[0]), .out_data_sum(ods[0]),
    .out_valid(ov[0]), .out_start(os[0]), .out_data(od[0])
  );

  sys_sum_stacker #(.BitSize(4), .NumOfNerves(4), .DepthIn(3), .DepthOut(2)) u_dut1 (
    .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_start(in_start), .in_data(in_data),
    .out_valid_sum(ovs[1]), .out_start_sum(oss[1]), .out_data_sum(ods[1]),
    .out_valid(ov[1]), .out_start(os[1]), .out_data(od[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Model state: input history per clock edge plus per-instance frame bookkeeping.
  int          e       = 0;
  int          lastrst = -1;
  logic [15:0] hd [MaxE];
  bit          hs [MaxE];
  int unsigned nsum     [2];
  bit          pend_v   [2];
  int unsigned pend_sum [2];
  int unsigned pend_idx [2];
  logic [7:0]  partial  [2];
  logic [7:0]  exp_od   [2];

  int unsigned sumq[$];
  int unsigned ssq[$];
  int unsigned wq0[$];
  int unsigned ws0[$];
  int unsigned wq1[$];
  int unsigned ws1[$];
  logic [15:0] elems [8];

  function automatic int unsigned addm(input int unsigned a, input int unsigned b);
`ifdef SYS_SUM_SATURATE_EN
    return (a + b > 15) ? 15 : a + b;
`else
    return (a + b) % 16;
`endif
  endfunction

  function automatic int unsigned qget(input int unsigned q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic clear_q();
    sumq.delete(); ssq.delete(); wq0.delete(); ws0.delete(); wq1.delete(); ws1.delete();
  endtask

  task automatic cycle(input bit v, input bit st, input logic [15:0] d, input bit r);
    int unsigned p0;
    int unsigned lane;
    int          idx;
    int unsigned depth;
    int unsigned pos;
    bit          sv;
    bit          e_ov, e_os, e_ss;
    in_valid = v;
    in_start = st;
    in_data  = d;
    res_n    = r;
    @(posedge clk);
    #1;
    if (e >= MaxE) begin
      $display("FAIL history: cycle budget exceeded at edge %0d", e);
      $fatal(1);
    end
    hd[e] = v ? d : 16'h0;
    hs[e] = v && st;
    if (r) lastrst = e;

    // Serial sum after this edge: lane k contributes the value it held k edges ago.
    p0 = 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      idx  = e - k;
      lane = (idx > lastrst) ? 32'(hd[idx][k*B +: B]) : 0;
      p0   = addm(p0, lane);
    end
    idx = e - (int'(N) - 1);
    sv  = (idx > lastrst) && hs[idx];

    for (int i = 0; i < 2; i++) begin
      depth = (i == 0) ? 2 : 3;
      e_ov = 1'b0; e_os = 1'b0; e_ss = 1'b0;
      if (r) begin
        nsum[i] = 0; pend_v[i] = 1'b0; partial[i] = 8'h0; exp_od[i] = 8'h0;
      end else begin
        if (pend_v[i]) begin
          pos = pend_idx[i] % W;
          partial[i][pos*B +: B] = pend_sum[i][3:0];
          if (pos == W - 1 || pend_idx[i] == depth - 1) begin
            exp_od[i]  = partial[i];
            e_ov       = 1'b1;
            e_os       = (pend_idx[i] - pos) == 0;
            partial[i] = 8'h0;
          end
        end
        pend_v[i]   = sv;
        pend_sum[i] = p0;
        pend_idx[i] = nsum[i] % depth;
        e_ss        = sv && (pend_idx[i] == 0);
        if (sv) nsum[i]++;
      end
      check($sformatf("d%0d_valid_sum@%0d", i, e), 32'(ovs[i]), 32'(sv));
      check($sformatf("d%0d_start_sum@%0d", i, e), 32'(oss[i]), 32'(e_ss));
      check($sformatf("d%0d_data_sum@%0d", i, e), 32'(ods[i]), p0);
      check($sformatf("d%0d_valid@%0d", i, e), 32'(ov[i]), 32'(e_ov));
      check($sformatf("d%0d_start@%0d", i, e), 32'(os[i]), 32'(e_os));
      check($sformatf("d%0d_data@%0d", i, e), 32'(od[i]), 32'(exp_od[i]));
    end

    if (ovs[0] === 1'b1) begin sumq.push_back(32'(ods[0])); ssq.push_back(32'(oss[0])); end
    if (ov[0] === 1'b1) begin wq0.push_back(32'(od[0])); ws0.push_back(32'(os[0])); end
    if (ov[1] === 1'b1) begin wq1.push_back(32'(od[1])); ws1.push_back(32'(os[1])); end
    e++;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) cycle(1'b0, 1'b0, 16'($urandom), 1'b0);
  endtask

  // Presents elems[0..depth-1] with the lane skew; rst_at asserts reset at that offset.
  task automatic drive_frame(input int depth, input int rst_at);
    logic [15:0] d;
    int          j;
    for (int o = 0; o < depth + int'(N) - 1; o++) begin
      d = 16'h0;
      for (int k = 0; k < int'(N); k++) begin
        j = o - (int'(N) - 1 - k);
        if (j >= 0 && j < depth) d[k*B +: B] = elems[j][k*B +: B];
      end
      cycle(1'b1, o < depth, d, o == rst_at);
    end
  endtask

  task automatic basic_elems();
    elems[0] = 16'h1321;
    elems[1] = 16'h1322;
  endtask

  initial begin
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);

    clear_q();
    basic_elems();
    drive_frame(2, -1);
    idle(8);
    check("basic_nsum", 32'(sumq.size()), 2);
    check("basic_sum0", qget(sumq, 0), 7);
    check("basic_sum1", qget(sumq, 1), 8);
    check("basic_sstart0", qget(ssq, 0), 1);
    check("basic_sstart1", qget(ssq, 1), 0);
    check("basic_nword", 32'(wq0.size()), 1);
    check("basic_word", qget(wq0, 0), 32'h87);
    check("basic_wstart", qget(ws0, 0), 1);

    clear_q();
    drive_frame(2, -1);
    idle(8);
    check("repeat_nword", 32'(wq0.size()), 1);
    check("repeat_word", qget(wq0, 0), 32'h87);
    check("repeat_wstart", qget(ws0, 0), 1);

    clear_q();
    elems[0] = 16'hFFFF;
    drive_frame(1, -1);
    idle(6);
`ifdef SYS_SUM_SATURATE_EN
    check("overflow_sum", qget(sumq, 0), 32'hF);
`else
    check("overflow_sum", qget(sumq, 0), 32'hC);
`endif
    cycle(1'b0, 1'b0, 16'h0, 1'b1);

    clear_q();
    for (int j = 0; j < 3; j++) elems[j] = 16'h1111;
    drive_frame(3, -1);
    idle(8);
    check("partial_nword", 32'(wq1.size()), 2);
    check("partial_word0", qget(wq1, 0), 32'h44);
    check("partial_start0", qget(ws1, 0), 1);
    check("partial_word1", qget(wq1, 1), 32'h04);
    check("partial_start1", qget(ws1, 1), 0);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);

    clear_q();
    basic_elems();
    drive_frame(2, 4);
    idle(8);
    check("abort_nword", 32'(wq0.size()), 0);
    clear_q();
    drive_frame(2, -1);
    idle(8);
    check("after_abort_word", qget(wq0, 0), 32'h87);
    check("after_abort_wstart", qget(ws0, 0), 1);

    clear_q();
    for (int c = 0; c < 4; c++) cycle(1'b0, 1'b1, 16'($urandom), 1'b0);
    idle(6);
    check("novalid_nsum", 32'(sumq.size()), 0);
    check("novalid_nword", 32'(wq0.size()), 0);
    drive_frame(2, -1);
    idle(8);
    check("novalid_next_word", qget(wq0, 0), 32'h87);
    check("novalid_next_wstart", qget(ws0, 0), 1);

    // Random traffic: free-running strobes, gaps, frames and occasional resets.
    for (int it = 0; it < 120; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        for (int j = 0; j < 3; j++) elems[j] = 16'($urandom);
        drive_frame(int'($urandom_range(1, 3)), -1);
      end else begin
        for (int c = 0; c < 10; c++)
          cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 16'($urandom),
                $urandom_range(0, 59) == 0);
      end
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
